dds_cmd_decoder: RTL and testbench

Byte-stream command decoder for a multi-channel DDS. It sits between the UART receiver/transmitter and a bank of phase accumulators. It accumulates a tuning word byte-by-byte into a shadow register, then commits it to one selected channel or to all channels at once. It also gates channel enables and, optionally, reads a channel's tuning word back over the UART transmitter.

---
 rtl/dds_cmd_decoder.sv | 140 ++++++++++++++
 tb/tb_dds_cmd_decoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_cmd_decoder.sv
// Byte-stream command decoder for a multi-channel DDS: shadow tuning-word load, per-channel/all commit, enables.
// Optional readback of the selected channel over the UART transmitter is compiled in with `define CMD_READBACK_EN.
module dds_cmd_decoder #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      received,
  input  logic [7:0]                rx_byte,
  input  logic                      tx_busy,
  output logic                      transmit,
  output logic [7:0]                tx_byte,
  output logic [CHANNELS-1:0]       en,
  output logic [CHANNELS*WIDTH-1:0] m,
  output logic [CHANNELS-1:0]       set
);

  localparam int NBYTES = WIDTH / 8;

`ifdef CMD_READBACK_EN
  typedef enum logic [1:0] {IDLE, DATA, TX} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

  state_t             state;
  logic [3:0]         op;
  logic [3:0]         arg;
  logic [3:0]         sel;
  logic [3:0]         load_idx;
  logic [WIDTH-1:0]   shadow;
  logic [CHANNELS-1:0] sel_mask;

  assign op       = rx_byte[7:4];
  assign arg      = rx_byte[3:0];
  assign sel_mask = CHANNELS'(1) << sel;

`ifdef CMD_READBACK_EN
  logic [WIDTH-1:0] snap;
  logic [WIDTH-1:0] sel_word;
  logic [3:0]       tx_cnt;

  // Word currently addressed by sel; captured into snap when READ is accepted.
  always_comb begin
    sel_word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (sel_mask[c]) sel_word = m[c*WIDTH +: WIDTH];
    end
  end
`else
  logic unused_tx_busy;

  assign unused_tx_busy = tx_busy;
  assign transmit       = 1'b0;
  assign tx_byte        = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register, including the wide shadow and m bank, is reset so a mid-command reset leaves no stale word behind.
      state    <= IDLE;
      sel      <= '0;
      load_idx <= '0;
      shadow   <= '0;
      en       <= '0;
      m        <= '0;
      set      <= '0;
`ifdef CMD_READBACK_EN
      snap     <= '0;
      tx_cnt   <= '0;
      transmit <= 1'b0;
      tx_byte  <= 8'h00;
`endif
    end else begin
      // NOTE: strobes default low here and are raised only by the branch below, so each lasts exactly one cycle.
      set <= '0;
`ifdef CMD_READBACK_EN
      transmit <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (received) begin
            case (op)
              4'h1: if (int'(arg) < CHANNELS) sel <= arg;
              4'h2: begin
                load_idx <= arg;
                state    <= DATA;
              end
              4'h3: begin
                for (int c = 0; c < CHANNELS; c++) begin
                  if (sel_mask[c]) m[c*WIDTH +: WIDTH] <= shadow;
                end
                set <= sel_mask;
              end
              4'h4: en <= arg[0] ? (en & ~sel_mask) : (en | sel_mask);
`ifdef CMD_READBACK_EN
              4'h5: begin
                snap   <= sel_word;
                tx_cnt <= '0;
                state  <= TX;
              end
`endif
              4'h6: begin
                m   <= {CHANNELS{shadow}};
                set <= '1;
              end
              default: ;
            endcase
          end
        end

        DATA: begin
          // Out-of-range byte slots match no lane, so the byte is consumed and dropped.
          if (received) begin
            for (int b = 0; b < NBYTES; b++) begin
              if (int'(load_idx) == b) shadow[b*8 +: 8] <= rx_byte;
            end
            state <= IDLE;
          end
        end

`ifdef CMD_READBACK_EN
        TX: begin
          if (!tx_busy && !transmit) begin
            transmit <= 1'b1;
            tx_byte  <= snap[7:0];
            snap     <= snap >> 8;
            tx_cnt   <= tx_cnt + 4'd1;
            if (int'(tx_cnt) == NBYTES - 1) state <= IDLE;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_cmd_decoder.sv
// Self-checking bench for dds_cmd_decoder: directed scenarios plus random byte streams against a word-level model.
// Readback scenarios are exercised when CMD_READBACK_EN is defined.
module tb_dds_cmd_decoder;

  localparam int CH = 2;
  localparam int W  = 32;
  localparam int NB = W / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            received;
  logic [7:0]      rx_byte;
  logic            tx_busy = 1'b0;
  logic            transmit;
  logic [7:0]      tx_byte;
  logic [CH-1:0]   en;
  logic [CH*W-1:0] m;
  logic [CH-1:0]   set;

  dds_cmd_decoder #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .received(received), .rx_byte(rx_byte), .tx_busy(tx_busy),
    .transmit(transmit), .tx_byte(tx_byte), .en(en), .m(m), .set(set)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for 10 cycles after every transmit pulse.
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy_cnt > 0) busy_cnt--;
      if (transmit) busy_cnt = 10;
    end
    tx_busy = (busy_cnt != 0);
  end

  // Reference model at command level.
  logic [W-1:0]  m_ref [CH];
  logic [CH-1:0] en_ref;
  logic [CH-1:0] set_ref;
  logic [W-1:0]  sh_ref;
  int            sel_ref;
  int            slot;     // pending byte slot for a LOAD, -1 when none

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [CH*W-1:0] m_pack();
    logic [CH*W-1:0] r;
    for (int c = 0; c < CH; c++) r[c*W +: W] = m_ref[c];
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) m_ref[c] = '0;
    en_ref  = '0;
    set_ref = '0;
    sh_ref  = '0;
    sel_ref = 0;
    slot    = -1;
  endtask

  task automatic model_cmd(input logic [7:0] b);
    int op;
    int arg;
    op      = int'(b[7:4]);
    arg     = int'(b[3:0]);
    set_ref = '0;
    if (slot >= 0) begin
      if (slot < NB) sh_ref[slot*8 +: 8] = b;
      slot = -1;
    end else begin
      case (op)
        1: if (arg < CH) sel_ref = arg;
        2: slot = arg;
        3: begin m_ref[sel_ref] = sh_ref; set_ref[sel_ref] = 1'b1; end
        4: en_ref[sel_ref] = ~b[0];
        6: begin for (int c = 0; c < CH; c++) m_ref[c] = sh_ref; set_ref = '1; end
        default: ;
      endcase
    end
  endtask

  // One clock: optional strobe, model update, compare at the following negedge.
  task automatic step(input logic r, input logic [7:0] b);
    received = r;
    rx_byte  = b;
    @(posedge clk);
    if (r) model_cmd(b);
    else set_ref = '0;
    @(negedge clk);
    received = 1'b0;
    check("m", m, m_pack());
    check("en", en, en_ref);
    check("set", set, set_ref);
`ifndef CMD_READBACK_EN
    check("transmit_idle", transmit, 1'b0);
`endif
  endtask

  task automatic load_word(input logic [W-1:0] w);
    logic [7:0] cmd;
    for (int i = 0; i < NB; i++) begin
      cmd = 8'h20 | 8'(i);
      step(1'b1, cmd);
      step(1'b1, w[i*8 +: 8]);
    end
  endtask

  initial begin
    logic [7:0] b;
    logic       r;
    logic [7:0] txq[$];
    logic       prev_tx;
    logic [W-1:0] rb_word;

    rst      = 1'b1;
    received = 1'b0;
    rx_byte  = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m", m, '0);
    check("rst_en", en, '0);
    check("rst_set", set, '0);
    check("rst_transmit", transmit, 1'b0);
    check("rst_tx_byte", tx_byte, 8'h00);
    rst = 1'b0;

    // Load and commit one channel.
    step(1'b1, 8'h11);
    load_word(32'h0002672A);
    step(1'b1, 8'h30);
    check("t1_m1", m[63:32], 32'h0002672A);
    check("t1_m0", m[31:0], 32'h0);
    check("t1_set", set, 2'b10);
    step(1'b0, 8'h00);
    check("t1_set_off", set, 2'b00);

    // Enable and disable.
    step(1'b1, 8'h40);
    check("t2_en_on", en, 2'b10);
    step(1'b1, 8'h41);
    check("t2_en_off", en, 2'b00);

    // Commit to all channels.
    load_word(32'h12345678);
    step(1'b1, 8'h60);
    check("t3_m", m, 64'h12345678_12345678);
    check("t3_set", set, 2'b11);
    step(1'b0, 8'h00);
    check("t3_set_off", set, 2'b00);

    // Data byte not decoded; bad SEL and LOAD arguments ignored.
    step(1'b1, 8'h20);
    step(1'b1, 8'h30);
    check("t4_no_set", set, 2'b00);
    step(1'b1, 8'h1F);
    step(1'b1, 8'h27);
    step(1'b1, 8'hFF);
    step(1'b1, 8'h30);
    check("t4_m1", m[63:32], 32'h12345630);
    check("t4_set", set, 2'b10);

`ifdef CMD_READBACK_EN
    // Readback of channel 1.
    load_word(32'h0002672A);
    step(1'b1, 8'h30);
    rb_word = m_ref[sel_ref];
    step(1'b1, 8'h50);
    prev_tx = 1'b0;
    for (int cyc = 0; cyc < 150; cyc++) begin
      received = (cyc == 15);
      rx_byte  = 8'h30;
      @(posedge clk);
      @(negedge clk);
      received = 1'b0;
      check("tx_drop_set", set, 2'b00);
      check("tx_single", prev_tx && transmit, 1'b0);
      if (transmit) txq.push_back(tx_byte);
      prev_tx = transmit;
    end
    check("tx_count", txq.size(), NB);
    for (int i = 0; i < NB; i++) begin
      check("tx_byte", (i < txq.size()) ? txq[i] : 8'hxx, rb_word[i*8 +: 8]);
    end
    check("tx_rb_word", rb_word, 32'h0002672A);
    step(1'b1, 8'h30);
    check("tx_after_set", set, 2'b10);
`else
    step(1'b1, 8'h50);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      check("ro_transmit", transmit, 1'b0);
      check("ro_tx_byte", tx_byte, 8'h00);
    end
    step(1'b1, 8'h30);
`endif

    // Random command streams, back-to-back strobes included.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 3) != 0);
      b = 8'($urandom);
`ifdef CMD_READBACK_EN
      if (b[7:4] == 4'h5) b[7:4] = 4'h7;
`endif
      step(r, b);
    end

    // Reset mid-DATA, coincident with a received strobe.
    step(1'b1, 8'h60);
    step(1'b1, 8'h40);
    step(1'b1, 8'h21);
    rst      = 1'b1;
    received = 1'b1;
    rx_byte  = 8'h30;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst      = 1'b0;
    received = 1'b0;
    check("rst2_m", m, '0);
    check("rst2_en", en, '0);
    check("rst2_set", set, '0);
    check("rst2_transmit", transmit, 1'b0);
    check("rst2_tx_byte", tx_byte, 8'h00);
    step(1'b1, 8'h30);
    check("rst2_m0", m[31:0], 32'h0);
    check("rst2_set_sel0", set, 2'b01);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
